iram_loader: RTL and testbench

- Hardware counterpart of the bench's memory preload: accepts a byte stream and writes it into the ppu instruction RAM from address 0.
- Zero-fills the unused remainder of the RAM.
- Holds the ppu core in reset during the whole load, then releases it.
- Sits between an external byte source (UART/debug bridge) and the IRAM write port plus the core reset input.

---
 rtl/iram_loader.sv | 111 +++++++++++
 tb/tb_iram_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iram_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iram_loader : streams a byte image into the ppu IRAM from address 0, zero-fills
//               the rest and holds the core in reset until the load completes.
// Optional: define IRAM_LOADER_CHECKSUM_EN for a running byte-sum of the image.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module iram_loader #(
  parameter int RAM_SIZE = 256,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_FILL    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_SIZE - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              accept;
  logic              at_last;

  assign accept    = (state == S_LOAD) && in_valid;
  assign at_last   = (addr_cnt == LAST_ADDR);
  assign in_ready  = (state == S_LOAD);
  assign ram_we    = accept || (state == S_FILL);
  assign ram_addr  = ram_we ? addr_cnt : '0;
  assign ram_wdata = accept ? in_data : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      addr_cnt <= '0;
      core_rst <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            addr_cnt <= '0;
            core_rst <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            addr_cnt <= addr_cnt + 1'b1;
            // Top address always ends the load; a missing last marks overflow.
            if (at_last) begin
              overflow <= !in_last;
              state    <= S_RELEASE;
            end else if (in_last) begin
              state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          addr_cnt <= addr_cnt + 1'b1;
          if (at_last) state <= S_RELEASE;
        end
        S_RELEASE: begin
          core_rst <= 1'b1;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if ((state == S_IDLE) && start) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + in_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iram_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_iram_loader : directed checks of the IRAM loader against hand-computed values.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_iram_loader;

`ifdef IRAM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready, ram_we, core_rst, busy, done, overflow;
  logic [7:0] ram_addr, ram_wdata, checksum;

  iram_loader #(.RAM_SIZE(256), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .core_rst(core_rst), .busy(busy), .done(done),
    .overflow(overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  int n_vec = 0, n_bad = 0;
  int cyc = 0, wr_cnt, fill_cnt, first_fill, done_cnt, done_cyc, last_wr_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Records this cycle's IRAM write and done pulse, then advances one clock.
  task automatic tick;
    #1;
    if (rst) begin
      if (ram_we) begin
        mem[ram_addr] = ram_wdata;
        wr_cnt++;
        if (!in_ready) begin
          if (fill_cnt == 0) first_fill = int'(ram_addr);
          fill_cnt++;
        end
        if (ram_addr == 8'hFF) last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    wr_cnt = 0; fill_cnt = 0; first_fill = -1; done_cnt = 0;
    done_cyc = -1; last_wr_cyc = -100;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
    tick(); tick(); tick();
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    clear_model();
    tick(); tick();
    #1;
    check("reset_outputs", {in_ready, ram_we, ram_addr, ram_wdata, core_rst, busy, done, overflow, checksum}, 0);
    rst = 1'b1;
    tick();

    // Short image: three bytes then zero fill of 3..255.
    clear_model();
    pulse_start();
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
    #1;
    check("short_first_write", {in_ready, ram_we, ram_addr, ram_wdata, core_rst}, {1'b1, 1'b1, 8'h00, 8'h11, 1'b0});
    tick();
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    wait_done("short");
    check("short_bytes", {mem[0], mem[1], mem[2]}, 24'h112233);
    check("short_fill_count", fill_cnt, 253);
    check("short_first_fill", first_fill, 3);
    check("short_fill_zero", {mem[3], mem[128], mem[255]}, 24'h000000);
    check("short_done_latency", done_cyc - last_wr_cyc, 2);
    check("short_end_flags", {core_rst, busy, overflow}, 3'b100);
    check("short_checksum", checksum, CK_EN ? 8'h66 : 8'h00);

    // Gapped stream: valid 1,0,0,1.
    clear_model();
    pulse_start();
    #1;
    check("restart_holds_core", {core_rst, busy}, 2'b01);
    send(8'hA5, 1'b0);
    #1; check("gap_no_write_a", ram_we, 1'b0);
    tick();
    #1; check("gap_no_write_b", ram_we, 1'b0);
    tick();
    send(8'h5A, 1'b1);
    wait_done("gap");
    check("gap_bytes", {mem[0], mem[1]}, 16'hA55A);
    check("gap_load_writes", wr_cnt - fill_cnt, 2);
    check("gap_first_fill", first_fill, 2);
    check("gap_checksum", checksum, CK_EN ? 8'hFF : 8'h00);

    // Exact fit: 256 bytes, last on the top address, no fill.
    clear_model();
    pulse_start();
    for (int i = 0; i < 256; i++) send(8'(i), i == 255);
    #1;
    check("fit_release_cycle", {busy, ram_we, in_ready}, 3'b100);
    wait_done("fit");
    check("fit_fill_count", fill_cnt, 0);
    check("fit_writes", wr_cnt, 256);
    check("fit_sample_byte", {mem[200], mem[255]}, 16'hC8FF);
    check("fit_overflow", overflow, 1'b0);
    check("fit_checksum", checksum, CK_EN ? 8'h80 : 8'h00);

    // Overflow: 257 bytes without in_last.
    clear_model();
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i) ^ 8'h5A; in_last = 1'b0;
      tick();
    end
    in_data = 8'hC3;
    #1;
    check("ovf_stall", {in_ready, ram_we, overflow}, 3'b001);
    wait_done("ovf");
    in_valid = 1'b0;
    check("ovf_writes", wr_cnt, 256);
    check("ovf_addr0_kept", mem[0], 8'h5A);
    check("ovf_sticky", {overflow, core_rst}, 2'b11);
    check("ovf_checksum", checksum, CK_EN ? 8'h80 : 8'h00);

    // start while busy must be ignored.
    clear_model();
    pulse_start();
    send(8'h77, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    pulse_start();
    #1;
    check("busy_start_ignored", {busy, ram_we, in_ready}, 3'b110);
    wait_done("busy");
    check("busy_writes", {wr_cnt[15:0], fill_cnt[15:0]}, {16'd256, 16'd255});
    check("busy_addr0", mem[0], 8'h77);

    // Asynchronous reset mid-stream, then a fresh load from address 0.
    clear_model();
    pulse_start();
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_outputs", {in_ready, ram_we, ram_addr, ram_wdata, core_rst, busy, done, overflow, checksum}, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    clear_model();
    pulse_start();
    in_valid = 1'b1; in_data = 8'h99; in_last = 1'b1;
    #1;
    check("midrst_restart_addr", {ram_we, ram_addr, ram_wdata}, {1'b1, 8'h00, 8'h99});
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    wait_done("midrst");
    check("midrst_checksum", checksum, CK_EN ? 8'h99 : 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
